usb_sie_rx: RTL and testbench

Receive-side packet decoder. Sits directly downstream of the UTM receiver and consumes its UTMI byte stream (data, rx_valid, rx_active, rx_error). Validates the PID, checks CRC5 on tokens and CRC16 on data packets, and extracts token fields. Streams data payload with the CRC stripped, and emits one-cycle status pulses to the device protocol engine.

---
 rtl/usb_sie_rx.sv | 263 ++++++++++++++++++++++++++
 tb/tb_usb_sie_rx.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_sie_rx.sv
`default_nettype none
// ============================================================================
// Module      : usb_sie_rx
// Description : USB receive-side packet decoder on a UTMI byte stream. Checks
//               the PID, CRC5 on tokens and CRC16 on data packets, strips the
//               CRC from the payload and pulses status to the protocol engine.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_sie_rx #(
    parameter int MAX_DATA_BYTES = 64
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [7:0]                            rx_data,
    input  logic                                  rx_valid,
    input  logic                                  rx_active,
    input  logic                                  rx_error,
    output logic                                  pkt_start,
    output logic [3:0]                            pid,
    output logic                                  token_valid,
    output logic                                  sof_valid,
    output logic [6:0]                            token_addr,
    output logic [3:0]                            token_endp,
    output logic [10:0]                           frame_num,
    output logic                                  hshk_valid,
    output logic [7:0]                            data_out,
    output logic                                  data_valid,
    output logic                                  data_done,
    output logic [$clog2(MAX_DATA_BYTES+1)-1:0]   byte_cnt,
    output logic                                  pkt_error
);

    localparam int                  c_CNT_W     = $clog2(MAX_DATA_BYTES + 1);
    localparam logic [c_CNT_W-1:0]  c_MAX_CNT   = c_CNT_W'(MAX_DATA_BYTES);
    localparam logic [4:0]          c_CRC5_RES  = 5'b01100;
    localparam logic [15:0]         c_CRC16_RES = 16'h800D;

    localparam logic [2:0] c_S_IDLE     = 3'd0;
    localparam logic [2:0] c_S_WAIT_PID = 3'd1;
    localparam logic [2:0] c_S_TOKEN    = 3'd2;
    localparam logic [2:0] c_S_DATA     = 3'd3;
    localparam logic [2:0] c_S_HSHK     = 3'd4;
    localparam logic [2:0] c_S_EVAL     = 3'd5;
    localparam logic [2:0] c_S_IGNORE   = 3'd6;

    function automatic logic [4:0] f_crc5(input logic [4:0] crc, input logic [7:0] d);
        logic [4:0] c;
        c = crc;
        for (int i = 0; i < 8; i++)
            c = (d[i] ^ c[4]) ? ({c[3:0], 1'b0} ^ 5'b00101) : {c[3:0], 1'b0};
        return c;
    endfunction

    function automatic logic [15:0] f_crc16(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++)
            c = (d[i] ^ c[15]) ? ({c[14:0], 1'b0} ^ 16'h8005) : {c[14:0], 1'b0};
        return c;
    endfunction

    logic [2:0]          r_state, w_state_nxt, w_kind;
    logic [1:0]          r_cnt, w_cnt_nxt;
    logic [7:0]          r_b1, w_b1_nxt, r_b2, w_b2_nxt;
    logic [4:0]          r_crc5, w_crc5_nxt;
    logic [15:0]         r_crc16, w_crc16_nxt;
    logic [7:0]          r_hold0, w_hold0_nxt, r_hold1, w_hold1_nxt;
    logic [1:0]          r_held, w_held_nxt;
    logic [3:0]          w_pid_nxt, w_endp_nxt;
    logic [6:0]          w_addr_nxt;
    logic [10:0]         w_frame_nxt;
    logic [7:0]          w_dout_nxt;
    logic [c_CNT_W-1:0]  w_bcnt_nxt;
    logic                w_start_nxt, w_tok_nxt, w_sof_nxt, w_hshk_nxt;
    logic                w_dv_nxt, w_done_nxt, w_err_nxt, w_pid_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_S_IDLE;
            r_cnt       <= '0;
            r_b1        <= '0;
            r_b2        <= '0;
            r_crc5      <= '0;
            r_crc16     <= '0;
            r_hold0     <= '0;
            r_hold1     <= '0;
            r_held      <= '0;
            pkt_start   <= 1'b0;
            pid         <= '0;
            token_valid <= 1'b0;
            sof_valid   <= 1'b0;
            token_addr  <= '0;
            token_endp  <= '0;
            frame_num   <= '0;
            hshk_valid  <= 1'b0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            data_done   <= 1'b0;
            byte_cnt    <= '0;
            pkt_error   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_b1        <= w_b1_nxt;
            r_b2        <= w_b2_nxt;
            r_crc5      <= w_crc5_nxt;
            r_crc16     <= w_crc16_nxt;
            r_hold0     <= w_hold0_nxt;
            r_hold1     <= w_hold1_nxt;
            r_held      <= w_held_nxt;
            pkt_start   <= w_start_nxt;
            pid         <= w_pid_nxt;
            token_valid <= w_tok_nxt;
            sof_valid   <= w_sof_nxt;
            token_addr  <= w_addr_nxt;
            token_endp  <= w_endp_nxt;
            frame_num   <= w_frame_nxt;
            hshk_valid  <= w_hshk_nxt;
            data_out    <= w_dout_nxt;
            data_valid  <= w_dv_nxt;
            data_done   <= w_done_nxt;
            byte_cnt    <= w_bcnt_nxt;
            pkt_error   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_b1_nxt    = r_b1;
        w_b2_nxt    = r_b2;
        w_crc5_nxt  = r_crc5;
        w_crc16_nxt = r_crc16;
        w_hold0_nxt = r_hold0;
        w_hold1_nxt = r_hold1;
        w_held_nxt  = r_held;
        w_pid_nxt   = pid;
        w_addr_nxt  = token_addr;
        w_endp_nxt  = token_endp;
        w_frame_nxt = frame_num;
        w_dout_nxt  = data_out;
        w_bcnt_nxt  = byte_cnt;
        w_start_nxt = 1'b0;
        w_tok_nxt   = 1'b0;
        w_sof_nxt   = 1'b0;
        w_hshk_nxt  = 1'b0;
        w_dv_nxt    = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_pid_ok    = (rx_data[7:4] == ~rx_data[3:0]);
        case (rx_data[3:0])
            4'b0001, 4'b1001, 4'b0101, 4'b1101: w_kind = c_S_TOKEN;
            4'b0011, 4'b1011:                   w_kind = c_S_DATA;
            4'b0010, 4'b1010, 4'b1110:          w_kind = c_S_HSHK;
            default:                            w_kind = c_S_IGNORE;
        endcase

        case (r_state)
            c_S_IDLE: begin
                if (rx_active) w_state_nxt = c_S_WAIT_PID;
            end
            c_S_WAIT_PID: begin
                if (rx_error) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = c_S_IGNORE;
                end else if (rx_valid) begin
                    if (w_pid_ok && (w_kind != c_S_IGNORE)) begin
                        w_start_nxt = 1'b1;
                        w_pid_nxt   = rx_data[3:0];
                        w_bcnt_nxt  = '0;
                        w_cnt_nxt   = '0;
                        w_held_nxt  = '0;
                        w_crc5_nxt  = 5'h1F;
                        w_crc16_nxt = 16'hFFFF;
                        w_state_nxt = w_kind;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = c_S_IGNORE;
                    end
                end else if (!rx_active) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            c_S_TOKEN, c_S_HSHK: begin
                if (rx_error) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = c_S_IGNORE;
                end else begin
                    if (rx_valid) begin
                        if (r_cnt == 2'd0) w_b1_nxt = rx_data;
                        if (r_cnt == 2'd1) w_b2_nxt = rx_data;
                        if (r_cnt < 2'd2) w_crc5_nxt = f_crc5(r_crc5, rx_data);
                        if (r_cnt != 2'd3) w_cnt_nxt = r_cnt + 2'd1;
                    end
                    if (!rx_active) w_state_nxt = c_S_EVAL;
                end
            end
            c_S_DATA: begin
                if (rx_error) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = c_S_IGNORE;
                end else if (rx_valid && (r_held == 2'd2) && (byte_cnt == c_MAX_CNT)) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = c_S_IGNORE;
                end else begin
                    // Two newest bytes stay held: at end of packet they are the CRC.
                    if (rx_valid) begin
                        w_crc16_nxt = f_crc16(r_crc16, rx_data);
                        w_hold1_nxt = r_hold0;
                        w_hold0_nxt = rx_data;
                        if (r_held == 2'd2) begin
                            w_dout_nxt = r_hold1;
                            w_dv_nxt   = 1'b1;
                            w_bcnt_nxt = byte_cnt + 1'b1;
                        end else begin
                            w_held_nxt = r_held + 2'd1;
                        end
                    end
                    if (!rx_active) w_state_nxt = c_S_EVAL;
                end
            end
            c_S_EVAL: begin
                if (rx_error) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = c_S_IGNORE;
                end else begin
                    w_state_nxt = c_S_IDLE;
                    // PID[1:0] identifies the packet class: 01 token, 11 data, 10 handshake.
                    case (pid[1:0])
                        2'b01: begin
                            if ((r_cnt == 2'd2) && (r_crc5 == c_CRC5_RES)) begin
                                if (pid == 4'b0101) begin
                                    w_sof_nxt   = 1'b1;
                                    w_frame_nxt = {r_b2[2:0], r_b1};
                                end else begin
                                    w_tok_nxt  = 1'b1;
                                    w_addr_nxt = r_b1[6:0];
                                    w_endp_nxt = {r_b2[2:0], r_b1[7]};
                                end
                            end else begin
                                w_err_nxt = 1'b1;
                            end
                        end
                        2'b11: begin
                            if ((r_held == 2'd2) && (r_crc16 == c_CRC16_RES)) w_done_nxt = 1'b1;
                            else                                              w_err_nxt  = 1'b1;
                        end
                        default: begin
                            if (r_cnt == 2'd0) w_hshk_nxt = 1'b1;
                            else               w_err_nxt  = 1'b1;
                        end
                    endcase
                end
            end
            c_S_IGNORE: begin
                if (!rx_active) w_state_nxt = c_S_IDLE;
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_usb_sie_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_sie_rx
// Description : Directed and randomized packet stimulus for usb_sie_rx, checked
//               against a packet-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_sie_rx;

    localparam int MAXB = 64;
    localparam int BCW  = $clog2(MAXB + 1);

    logic           clk = 1'b0;
    logic           rst;
    logic [7:0]     rx_data;
    logic           rx_valid, rx_active, rx_error;
    logic           pkt_start, token_valid, sof_valid, hshk_valid;
    logic           data_valid, data_done, pkt_error;
    logic [3:0]     pid, token_endp;
    logic [6:0]     token_addr;
    logic [10:0]    frame_num;
    logic [7:0]     data_out;
    logic [BCW-1:0] byte_cnt;

    usb_sie_rx #(.MAX_DATA_BYTES(MAXB)) u_dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_active(rx_active), .rx_error(rx_error), .pkt_start(pkt_start),
        .pid(pid), .token_valid(token_valid), .sof_valid(sof_valid),
        .token_addr(token_addr), .token_endp(token_endp), .frame_num(frame_num),
        .hshk_valid(hshk_valid), .data_out(data_out), .data_valid(data_valid),
        .data_done(data_done), .byte_cnt(byte_cnt), .pkt_error(pkt_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // pulse monitor, sampled on the inactive edge
    int n_start = 0, n_tok = 0, n_sof = 0, n_hshk = 0, n_dv = 0, n_done = 0, n_err = 0;
    logic [7:0] got[$];
    always @(negedge clk) begin
        if (pkt_start)   n_start++;
        if (token_valid) n_tok++;
        if (sof_valid)   n_sof++;
        if (hshk_valid)  n_hshk++;
        if (data_done)   n_done++;
        if (pkt_error)   n_err++;
        if (data_valid) begin
            n_dv++;
            got.push_back(data_out);
        end
    end

    // reference model state
    logic [7:0]  pkt[$];
    logic [3:0]  m_pid   = '0;
    logic [6:0]  m_addr  = '0;
    logic [3:0]  m_endp  = '0;
    logic [10:0] m_frame = '0;
    int          m_bcnt  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // USB CRCs in their reflected software form; results are what goes on the wire
    function automatic logic [4:0] m_crc5(input logic [10:0] f);
        logic [4:0] c = 5'h1F;
        for (int i = 0; i < 11; i++)
            c = (c[0] ^ f[i]) ? ((c >> 1) ^ 5'h14) : (c >> 1);
        return ~c;
    endfunction

    function automatic logic [15:0] m_crc16(input int lo, input int hi);
        logic [15:0] c = 16'hFFFF;
        for (int i = lo; i <= hi; i++) begin
            c ^= {8'h00, pkt[i]};
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic bit m_supported(input logic [3:0] p);
        return p inside {4'h1, 4'h9, 4'h5, 4'hD, 4'h3, 4'hB, 4'h2, 4'hA, 4'hE};
    endfunction

    task automatic gen_token(input logic [3:0] p, input logic [10:0] f);
        pkt = {};
        pkt.push_back({~p, p});
        pkt.push_back(f[7:0]);
        pkt.push_back({m_crc5(f), f[10:8]});
    endtask

    task automatic gen_data(input logic [3:0] p, input int len);
        logic [15:0] c;
        pkt = {};
        pkt.push_back({~p, p});
        for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
        c = m_crc16(1, len);
        pkt.push_back(c[7:0]);
        pkt.push_back(c[15:8]);
    endtask

    task automatic send(input int err_at, input bit coincide);
        int last = pkt.size() - 1;
        @(negedge clk);
        rx_active = 1'b1;
        repeat (1 + $urandom_range(0, 1)) @(negedge clk);
        for (int i = 0; i <= last; i++) begin
            rx_data  = pkt[i];
            rx_valid = 1'b1;
            rx_error = (i == err_at);
            if (coincide && i == last) rx_active = 1'b0;
            @(negedge clk);
            rx_valid = 1'b0;
            rx_error = 1'b0;
            if (i != last) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rx_active = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic run_check(input string tag, input int err_at, input bit coincide);
        int s_start = n_start, s_tok = n_tok, s_sof = n_sof, s_hshk = n_hshk;
        int s_dv = n_dv, s_done = n_done, s_err = n_err;
        int base = got.size();
        int n = pkt.size();
        int lim, L;
        bit ef;
        int e_start = 0, e_tok = 0, e_sof = 0, e_hshk = 0, e_done = 0, e_err = 0, e_pay = 0;
        logic [7:0] p;
        logic [15:0] c16;
        logic [31:0] v;

        ef  = (err_at >= 0) && (err_at < n);
        lim = ef ? err_at : n;
        if (n > 0) begin
            p = pkt[0];
            if (lim == 0) begin
                e_err = 1;
            end else if ((p[7:4] != ~p[3:0]) || !m_supported(p[3:0])) begin
                e_err = 1;
            end else begin
                e_start = 1;
                m_pid   = p[3:0];
                m_bcnt  = 0;
                L       = lim - 1;
                if (p[1:0] == 2'b01) begin
                    if (!ef && L == 2 && m_crc5({pkt[2][2:0], pkt[1]}) == pkt[2][7:3]) begin
                        if (p[3:0] == 4'h5) begin
                            e_sof   = 1;
                            m_frame = {pkt[2][2:0], pkt[1]};
                        end else begin
                            e_tok  = 1;
                            m_addr = pkt[1][6:0];
                            m_endp = {pkt[2][2:0], pkt[1][7]};
                        end
                    end else begin
                        e_err = 1;
                    end
                end else if (p[1:0] == 2'b11) begin
                    if (L > MAXB + 2) begin
                        e_pay = MAXB;
                        e_err = 1;
                    end else begin
                        e_pay = (L >= 2) ? L - 2 : 0;
                        if (!ef && L >= 2) begin
                            c16 = m_crc16(1, L - 2);
                            if (pkt[L - 1] == c16[7:0] && pkt[L] == c16[15:8]) e_done = 1;
                            else                                               e_err  = 1;
                        end else begin
                            e_err = 1;
                        end
                    end
                    m_bcnt = e_pay;
                end else begin
                    if (!ef && L == 0) e_hshk = 1;
                    else               e_err  = 1;
                end
            end
        end

        send(err_at, coincide);

        chk({tag, " pkt_start"},   n_start - s_start, e_start);
        chk({tag, " token_valid"}, n_tok - s_tok,     e_tok);
        chk({tag, " sof_valid"},   n_sof - s_sof,     e_sof);
        chk({tag, " hshk_valid"},  n_hshk - s_hshk,   e_hshk);
        chk({tag, " data_done"},   n_done - s_done,   e_done);
        chk({tag, " pkt_error"},   n_err - s_err,     e_err);
        chk({tag, " data_valid"},  n_dv - s_dv,       e_pay);
        chk({tag, " pid"},         pid,        m_pid);
        chk({tag, " token_addr"},  token_addr, m_addr);
        chk({tag, " token_endp"},  token_endp, m_endp);
        chk({tag, " frame_num"},   frame_num,  m_frame);
        chk({tag, " byte_cnt"},    byte_cnt,   m_bcnt);
        for (int i = 0; i < e_pay; i++) begin
            v = (base + i < got.size()) ? {24'h0, got[base + i]} : 32'hFFFF_FFFF;
            chk($sformatf("%s payload[%0d]", tag, i), v, pkt[1 + i]);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " pkt_start"},   pkt_start,   0);
        chk({tag, " pid"},         pid,         0);
        chk({tag, " token_valid"}, token_valid, 0);
        chk({tag, " sof_valid"},   sof_valid,   0);
        chk({tag, " token_addr"},  token_addr,  0);
        chk({tag, " token_endp"},  token_endp,  0);
        chk({tag, " frame_num"},   frame_num,   0);
        chk({tag, " hshk_valid"},  hshk_valid,  0);
        chk({tag, " data_out"},    data_out,    0);
        chk({tag, " data_valid"},  data_valid,  0);
        chk({tag, " data_done"},   data_done,   0);
        chk({tag, " byte_cnt"},    byte_cnt,    0);
        chk({tag, " pkt_error"},   pkt_error,   0);
    endtask

    initial begin
        int r, len, e_at;
        bit co;
        logic [3:0] tp;
        rst = 1'b1; rx_data = '0; rx_valid = 1'b0; rx_active = 1'b0; rx_error = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        pkt = '{8'h2D, 8'h00, 8'h10};
        run_check("setup", -1, 1'b0);
        chk("setup pid_d", pid, 4'hD);
        pkt = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
        run_check("getdesc", -1, 1'b0);
        chk("getdesc byte_cnt8", byte_cnt, 8);
        pkt = '{8'hC3, 8'h00, 8'h00};
        run_check("zlp", -1, 1'b1);
        pkt = '{8'hD2};
        run_check("ack", -1, 1'b0);
        chk("ack pid_2", pid, 4'h2);
        pkt = '{8'h2D, 8'h00, 8'h11};
        run_check("bad_crc5", -1, 1'b0);
        pkt = '{8'h2C, 8'h00, 8'h10};
        run_check("bad_pid", -1, 1'b0);
        pkt = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h95};
        run_check("bad_crc16", -1, 1'b0);
        gen_data(4'h3, 10);
        run_check("rx_err_mid", 6, 1'b0);
        pkt = '{8'hD2};
        run_check("ack_after_err", -1, 1'b0);
        pkt = {};
        run_check("empty", -1, 1'b0);
        gen_data(4'hB, MAXB);
        run_check("max_len", -1, 1'b0);
        gen_data(4'hB, MAXB + 1);
        run_check("overflow", -1, 1'b0);
        pkt = '{8'hD2, 8'h00};
        run_check("ack_extra", -1, 1'b0);
        gen_token(4'h5, 11'h5A3);
        run_check("sof", -1, 1'b1);

        // reset in the middle of a token abandons it silently
        @(negedge clk);
        rx_active = 1'b1;
        @(negedge clk);
        rx_data = 8'h69; rx_valid = 1'b1;
        @(negedge clk);
        rx_data = 8'h00;
        #2 rst = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0; rx_active = 1'b0;
        chk_all_zero("rst_mid");
        rst = 1'b0;
        m_pid = '0; m_addr = '0; m_endp = '0; m_frame = '0; m_bcnt = 0;
        repeat (2) @(negedge clk);
        gen_token(4'h9, 11'h2B7);
        run_check("after_rst", -1, 1'b0);

        for (int k = 0; k < 50; k++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: begin
                    case ($urandom_range(0, 3))
                        0: tp = 4'h1;
                        1: tp = 4'h9;
                        2: tp = 4'h5;
                        default: tp = 4'hD;
                    endcase
                    gen_token(tp, 11'($urandom));
                end
                3, 4, 5: gen_data($urandom_range(0, 1) ? 4'h3 : 4'hB, $urandom_range(0, 20));
                6: begin
                    pkt = '{8'hD2};
                    pkt[0] = ($urandom_range(0, 1)) ? 8'h5A : 8'h1E;
                    if ($urandom_range(0, 3) == 0) pkt.push_back(8'($urandom));
                end
                7: begin
                    pkt = {};
                    len = $urandom_range(0, 4);
                    for (int j = 0; j < len; j++) pkt.push_back(8'($urandom));
                end
                default: gen_data(4'h3, MAXB - 1 + $urandom_range(0, 2));
            endcase
            if (pkt.size() > 0 && $urandom_range(0, 4) == 0)
                pkt[$urandom_range(0, pkt.size() - 1)] ^= 8'(1 << $urandom_range(0, 7));
            e_at = (pkt.size() > 0 && $urandom_range(0, 6) == 0) ? $urandom_range(0, pkt.size() - 1) : -1;
            co   = ($urandom_range(0, 2) == 0);
            run_check($sformatf("rnd%0d", k), e_at, co);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
